hazard_scoreboard: RTL and testbench

Parametrised next-generation pipeline hazard controller for the five-stage core. It keeps all load-use, forwarding and branch-prediction handling of the single-cycle-latency hazard logic. It adds a registered scoreboard that tracks destination registers of in-flight long-latency operations (mul/div, future FP), so decode stalls on RAW/WAW against them. It sits between decode/execute control and the datapath muxes, and drives all stall, flush and forward selects.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard control: load-use, forwarding, branch redirect, plus a
// scoreboard of in-flight long-latency destinations. Optional perf counters: HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_ADDR_BITS   = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_BITS        = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_ADDR_BITS-1:0] readRegister1D,
    input  logic [REG_ADDR_BITS-1:0] readRegister2D,
    input  logic                     reg1UsedD,
    input  logic                     reg2UsedD,
    input  logic [REG_ADDR_BITS-1:0] writeRegD,
    input  logic                     regWriteD,
    input  logic                     longOpD,
    input  logic                     longDoneValid,
    input  logic [REG_ADDR_BITS-1:0] longDoneReg,
    input  logic [REG_ADDR_BITS-1:0] readRegister1E,
    input  logic [REG_ADDR_BITS-1:0] readRegister2E,
    input  logic [REG_ADDR_BITS-1:0] writeRegE,
    input  logic [REG_ADDR_BITS-1:0] writeRegM,
    input  logic [REG_ADDR_BITS-1:0] writeRegW,
    input  logic                     regWriteM,
    input  logic                     regWriteW,
    input  logic                     loadE,
    input  logic                     csrrs,
    input  logic                     bubble,
    input  logic [63:0]              PCD,
    input  logic [63:0]              PCNextE,
    output logic                     PCSrc,
    output logic                     stallF,
    output logic                     stallD,
    output logic                     flushD,
    output logic                     flushE,
    output logic [1:0]               forwardAE,
    output logic [1:0]               forwardBE,
    output logic [CNT_BITS-1:0]      outstanding,
    output logic                     scbError,
    output logic [31:0]              stallCycles,
    output logic [31:0]              flushCycles
);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_BITS-1:0] r_count;
    logic                r_scb_error;

    logic [NUM_REGS-1:0] w_pending;
    logic [CNT_BITS-1:0] w_count;
    logic                w_valid_pred;
    logic                w_load_stall;
    logic                w_scb_stall;
    logic                w_hazard;
    logic                w_issue;
    logic                w_done_ok;

    // While reset is asserted, hazard decisions see an empty scoreboard.
    assign w_pending = reset ? r_pending : '0;
    assign w_count   = reset ? r_count : '0;

    assign w_valid_pred = (PCD == PCNextE) | bubble;
    assign PCSrc        = w_valid_pred;

    always_comb begin
        forwardAE = 2'b00;
        if (regWriteM && writeRegM != '0 && writeRegM == readRegister1E)
            forwardAE = 2'b10;
        else if (regWriteW && writeRegW != '0 && writeRegW == readRegister1E)
            forwardAE = 2'b01;
        forwardBE = 2'b00;
        if (csrrs)
            forwardBE = 2'b00;
        else if (regWriteM && writeRegM != '0 && writeRegM == readRegister2E)
            forwardBE = 2'b10;
        else if (regWriteW && writeRegW != '0 && writeRegW == readRegister2E)
            forwardBE = 2'b01;
    end

    assign w_load_stall = loadE & (writeRegE != '0) &
                          ((reg1UsedD & (readRegister1D == writeRegE)) |
                           (reg2UsedD & (readRegister2D == writeRegE)));

    assign w_scb_stall = (reg1UsedD & w_pending[readRegister1D]) |
                         (reg2UsedD & w_pending[readRegister2D]) |
                         (regWriteD & w_pending[writeRegD]) |
                         (longOpD & (w_count == CNT_BITS'(MAX_OUTSTANDING)));

    assign w_hazard = w_load_stall | w_scb_stall;
    assign stallF   = w_valid_pred & w_hazard;
    assign stallD   = w_valid_pred & w_hazard;
    assign flushD   = ~w_valid_pred;
    assign flushE   = ~w_valid_pred | w_hazard;

    assign w_issue   = longOpD & regWriteD & (writeRegD != '0) & ~stallD & ~flushD;
    assign w_done_ok = longDoneValid & r_pending[longDoneReg] & (r_count != '0);

    // Clear before set so an issue and completion naming the same register leaves it pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending   <= '0;
            r_count     <= '0;
            r_scb_error <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~({{(NUM_REGS-1){1'b0}}, w_done_ok} << longDoneReg))
                       | ({{(NUM_REGS-1){1'b0}}, w_issue} << writeRegD);
            if (w_issue && !w_done_ok)
                r_count <= r_count + CNT_BITS'(1);
            else if (w_done_ok && !w_issue)
                r_count <= r_count - CNT_BITS'(1);
            if (longDoneValid && !w_done_ok)
                r_scb_error <= 1'b1;
        end
    end

    assign outstanding = r_count;
    assign scbError    = r_scb_error;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (stallD && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if ((flushD || flushE) && r_flush_cycles != '1)
                r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign stallCycles = r_stall_cycles;
    assign flushCycles = r_flush_cycles;
`else
    assign stallCycles = 32'd0;
    assign flushCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic, checked
// against a queue-of-registers reference model through an expected-output queue.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readRegister1D, readRegister2D, writeRegD, longDoneReg;
    logic [4:0]  readRegister1E, readRegister2E, writeRegE, writeRegM, writeRegW;
    logic        reg1UsedD, reg2UsedD, regWriteD, longOpD, longDoneValid;
    logic        regWriteM, regWriteW, loadE, csrrs, bubble;
    logic [63:0] PCD, PCNextE;
    logic        PCSrc, stallF, stallD, flushD, flushE, scbError;
    logic [1:0]  forwardAE, forwardBE;
    logic [2:0]  outstanding;
    logic [31:0] stallCycles, flushCycles;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .readRegister1D(readRegister1D), .readRegister2D(readRegister2D),
        .reg1UsedD(reg1UsedD), .reg2UsedD(reg2UsedD),
        .writeRegD(writeRegD), .regWriteD(regWriteD), .longOpD(longOpD),
        .longDoneValid(longDoneValid), .longDoneReg(longDoneReg),
        .readRegister1E(readRegister1E), .readRegister2E(readRegister2E),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteM(regWriteM), .regWriteW(regWriteW), .loadE(loadE),
        .csrrs(csrrs), .bubble(bubble), .PCD(PCD), .PCNextE(PCNextE),
        .PCSrc(PCSrc), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .outstanding(outstanding), .scbError(scbError),
        .stallCycles(stallCycles), .flushCycles(flushCycles)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rs1d, rs2d, wd, dreg, rs1e, rs2e, we, wm, ww;
        logic        u1, u2, rwd, lop, dv, rwm, rww, lde, csr, bub;
        logic [63:0] pcd, pcn;
    } stim_t;

    // Expected vector: {PCSrc, stallF, stallD, flushD, flushE, fwdA, fwdB, outstanding, scbError, stallCycles, flushCycles}
    logic [76:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: in-flight destinations held as a plain list of register numbers.
    int          m_q[$];
    logic        m_err = 1'b0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    function automatic bit m_has(input logic [4:0] r);
        foreach (m_q[i]) if (m_q[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.wm != 0 && s.wm == rs) return 2'd2;
        if (s.rww && s.ww != 0 && s.ww == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst  = ($urandom_range(0, 59) != 0);
        s.rs1d = 5'($urandom_range(0, 7));
        s.rs2d = 5'($urandom_range(0, 7));
        s.wd   = 5'($urandom_range(0, 7));
        s.u1   = 1'($urandom_range(0, 1));
        s.u2   = 1'($urandom_range(0, 1));
        s.rwd  = ($urandom_range(0, 3) != 0);
        s.lop  = ($urandom_range(0, 2) == 0);
        if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            s.dv   = 1'b1;
            s.dreg = 5'(m_q[$urandom_range(0, m_q.size() - 1)]);
        end else begin
            s.dv   = ($urandom_range(0, 79) == 0);
            s.dreg = 5'($urandom_range(0, 31));
        end
        s.rs1e = 5'($urandom_range(0, 7));
        s.rs2e = 5'($urandom_range(0, 7));
        s.we   = 5'($urandom_range(0, 7));
        s.wm   = 5'($urandom_range(0, 7));
        s.ww   = 5'($urandom_range(0, 7));
        s.rwm  = 1'($urandom_range(0, 1));
        s.rww  = 1'($urandom_range(0, 1));
        s.lde  = ($urandom_range(0, 3) == 0);
        s.csr  = ($urandom_range(0, 5) == 0);
        s.bub  = ($urandom_range(0, 5) == 0);
        s.pcn  = 64'h2000;
        s.pcd  = ($urandom_range(0, 7) == 0) ? 64'h1000 : 64'h2000;
        return s;
    endfunction

    // Drives one cycle after the clock edge, records the expected outputs, then
    // advances the model to the state the next edge should produce.
    task automatic drive(input stim_t s);
        bit vp, ls, ss, stl, fd, fe, iss, dok;
        logic [1:0] fa, fb;
        @(posedge clk);
        #1;
        reset = s.rst;
        readRegister1D = s.rs1d; readRegister2D = s.rs2d;
        reg1UsedD = s.u1; reg2UsedD = s.u2;
        writeRegD = s.wd; regWriteD = s.rwd; longOpD = s.lop;
        longDoneValid = s.dv; longDoneReg = s.dreg;
        readRegister1E = s.rs1e; readRegister2E = s.rs2e;
        writeRegE = s.we; writeRegM = s.wm; writeRegW = s.ww;
        regWriteM = s.rwm; regWriteW = s.rww; loadE = s.lde;
        csrrs = s.csr; bubble = s.bub; PCD = s.pcd; PCNextE = s.pcn;

        vp  = (s.pcd == s.pcn) || s.bub;
        ls  = s.lde && s.we != 0 && ((s.u1 && s.rs1d == s.we) || (s.u2 && s.rs2d == s.we));
        ss  = s.rst && ((s.u1 && m_has(s.rs1d)) || (s.u2 && m_has(s.rs2d)) ||
                        (s.rwd && m_has(s.wd)) || (s.lop && m_q.size() == 4));
        stl = vp && (ls || ss);
        fd  = !vp;
        fe  = !vp || ls || ss;
        fa  = fwd(s.rs1e, s);
        fb  = s.csr ? 2'd0 : fwd(s.rs2e, s);
        exp_q.push_back({vp, stl, stl, fd, fe, fa, fb, 3'(m_q.size()), m_err, m_sc, m_fc});

        iss = s.lop && s.rwd && s.wd != 0 && !stl && !fd;
        dok = s.dv && m_has(s.dreg) && m_q.size() != 0;
        if (!s.rst) begin
            m_q.delete();
            m_err = 1'b0;
            m_sc  = '0;
            m_fc  = '0;
        end else begin
            if (dok) begin
                for (int i = 0; i < m_q.size(); i++)
                    if (m_q[i] == int'(s.dreg)) begin
                        m_q.delete(i);
                        break;
                    end
            end
            if (iss) m_q.push_back(int'(s.wd));
            if (s.dv && !dok) m_err = 1'b1;
`ifdef HAZARD_PERF_EN
            if (stl && m_sc != '1) m_sc = m_sc + 1;
            if ((fd || fe) && m_fc != '1) m_fc = m_fc + 1;
`endif
        end
    endtask

    initial begin : monitor
        logic [76:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {PCSrc, stallF, stallD, flushD, flushE, forwardAE, forwardBE,
                     outstanding, scbError, stallCycles, flushCycles};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: actual=%h required=%h", $time, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    wait_cycles;
        reset = 1'b0;
        {readRegister1D, readRegister2D, writeRegD, longDoneReg} = '0;
        {readRegister1E, readRegister2E, writeRegE, writeRegM, writeRegW} = '0;
        {reg1UsedD, reg2UsedD, regWriteD, longOpD, longDoneValid} = '0;
        {regWriteM, regWriteW, loadE, csrrs, bubble} = '0;
        PCD = '0;
        PCNextE = '0;

        s = idle(); s.rst = 1'b0;
        drive(s); drive(s);
        drive(idle());

        // load-use: load x5 in E, add x6,x5,x1 in D
        s = idle(); s.lde = 1; s.we = 5; s.rs1d = 5; s.rs2d = 1; s.u1 = 1; s.u2 = 1;
        s.wd = 6; s.rwd = 1; s.rs1e = 5; s.rwm = 1; s.wm = 5;
        drive(s);

        // div to x7, dependent reader stalls until the cycle after completion
        s = idle(); s.lop = 1; s.rwd = 1; s.wd = 7;
        drive(s);
        s = idle(); s.u1 = 1; s.rs1d = 7;
        drive(s); drive(s);
        s.dv = 1; s.dreg = 7;
        drive(s);
        s.dv = 0;
        drive(s);

        // fill to MAX_OUTSTANDING, blocked 5th op, completion frees a slot
        for (int r = 1; r <= 4; r++) begin
            s = idle(); s.lop = 1; s.rwd = 1; s.wd = 5'(r);
            drive(s);
        end
        s = idle(); s.lop = 1; s.rwd = 1; s.wd = 9;
        drive(s);
        s.dv = 1; s.dreg = 2;
        drive(s);
        s.dv = 0;
        drive(s);
        drive(idle());

        // WAW on x3 with a concurrent mispredict
        s = idle(); s.rwd = 1; s.wd = 3; s.pcd = 64'h40; s.pcn = 64'h80;
        drive(s);
        drive(idle());

        // completion of a non-pending register, then reset clears everything
        s = idle(); s.dv = 1; s.dreg = 12;
        drive(s);
        drive(idle()); drive(idle());
        s = idle(); s.rst = 1'b0;
        drive(s);
        drive(idle());

        for (int n = 0; n < 3000; n++) drive(rnd());

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: actual=%0d pending checks required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
